// File: rtl/bcd_pkg.sv
// Shared constants and types for the single-digit BCD adder.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int SUM_W   = DIGIT_W + 1;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SUM_W-1:0]   bsum_t;

    // A 4-bit code above nine is not a decimal digit.
    function automatic logic digit_illegal(input digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add with +6 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout,
    output logic               err
);

    bsum_t z_bin;
    logic  corr;

    // Full 5-bit binary sum, then correct whenever it leaves the decimal range.
    // The +6 is done on the low nibble only: (z + 6) mod 16 == (z[3:0] + 6) mod 16,
    // which also covers the z >= 16 native-carry case.
    always_comb begin
        z_bin = bsum_t'(a) + bsum_t'(b) + bsum_t'(cin);
        corr  = z_bin > bsum_t'(BCD_MAX);
        s     = corr ? (z_bin[DIGIT_W-1:0] + BCD_CORR) : z_bin[DIGIT_W-1:0];
        cout  = corr;
        err   = digit_illegal(a) || digit_illegal(b);
    end

endmodule

// File: rtl/bcd_adder_core.sv
// BCD digit adder: combinational result plus a one-cycle registered copy
// and a sticky illegal-digit flag.
module bcd_adder_core
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               in_valid,
    output logic [DIGIT_W-1:0] s_bcd,
    output logic               cout_bcd,
    output logic               err_bcd,
    output logic [DIGIT_W-1:0] s_bcd_q,
    output logic               cout_bcd_q,
    output logic               err_q,
    output logic               out_valid,
    output logic               err_sticky
);

    logic [DIGIT_W-1:0] s_bcd_d;
    logic               cout_bcd_d;
    logic               err_d;
    logic               out_valid_q;
    logic               err_sticky_q;
    logic               err_sticky_d;

    bcd_digit_add u_digit_add (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s_bcd),
        .cout (cout_bcd),
        .err  (err_bcd)
    );

    // Next-state: capture the combinational result on valid input, else hold.
    always_comb begin
        s_bcd_d      = s_bcd_q;
        cout_bcd_d   = cout_bcd_q;
        err_d        = err_q;
        err_sticky_d = err_sticky_q | (in_valid & err_bcd);
        if (in_valid) begin
            s_bcd_d    = s_bcd;
            cout_bcd_d = cout_bcd;
            err_d      = err_bcd;
        end
    end

    // Register stage; reset wins over a same-cycle valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_bcd_q      <= '0;
            cout_bcd_q   <= 1'b0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            s_bcd_q      <= s_bcd_d;
            cout_bcd_q   <= cout_bcd_d;
            err_q        <= err_d;
            out_valid_q  <= in_valid;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_bcd_adder_core.sv
// Randomized and directed bench for bcd_adder_core with a queued scoreboard.
module tb_bcd_adder_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] s_bcd;
    logic       cout_bcd;
    logic       err_bcd;
    logic [3:0] s_bcd_q;
    logic       cout_bcd_q;
    logic       err_q;
    logic       out_valid;
    logic       err_sticky;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int s;
        int c;
        int e;
        int ov;
        int st;
    } reg_exp_t;

    reg_exp_t exp_q[$];

    // Model of the registered state after each edge.
    int m_s = 0, m_c = 0, m_e = 0, m_ov = 0, m_st = 0;

    bcd_adder_core dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .in_valid   (in_valid),
        .s_bcd      (s_bcd),
        .cout_bcd   (cout_bcd),
        .err_bcd    (err_bcd),
        .s_bcd_q    (s_bcd_q),
        .cout_bcd_q (cout_bcd_q),
        .err_q      (err_q),
        .out_valid  (out_valid),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Decimal reference: legal digits add as ordinary decimal numbers;
    // illegal ones fall back to the raw binary-sum correction rule.
    function automatic void ref_add(input int ra, input int rb, input int rc,
                                    output int rs, output int rco, output int re);
        int z;
        z  = ra + rb + rc;
        re = (ra > 9 || rb > 9) ? 1 : 0;
        if (re == 0) begin
            rs  = z % 10;
            rco = z / 10;
        end else begin
            rco = (z > 9) ? 1 : 0;
            rs  = (rco == 1) ? (z + 6) % 16 : z;
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One cycle of stimulus: drive, check combinational outputs, push the
    // expected registered state for the monitor.
    task automatic step(input int va, input int vb, input int vc, input int vv, input int vr);
        int es, ec, ee;
        reg_exp_t x;
        @(negedge clk);
        a = 4'(va);
        b = 4'(vb);
        cin = vc[0];
        in_valid = vv[0];
        rst = vr[0];
        #1;
        ref_add(va, vb, vc, es, ec, ee);
        check("s_bcd", int'(s_bcd), es);
        check("cout_bcd", int'(cout_bcd), ec);
        check("err_bcd", int'(err_bcd), ee);
        if (vr != 0) begin
            m_s = 0; m_c = 0; m_e = 0; m_ov = 0; m_st = 0;
        end else begin
            if (vv != 0) begin
                m_s = es; m_c = ec; m_e = ee;
                if (ee != 0) m_st = 1;
            end
            m_ov = vv;
        end
        x.s = m_s; x.c = m_c; x.e = m_e; x.ov = m_ov; x.st = m_st;
        exp_q.push_back(x);
    endtask

    // Monitor: after every edge take the oldest expectation and compare.
    initial begin
        reg_exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("out_valid", int'(out_valid), x.ov);
                check("err_sticky", int'(err_sticky), x.st);
                if (x.ov != 0) begin
                    check("s_bcd_q", int'(s_bcd_q), x.s);
                    check("cout_bcd_q", int'(cout_bcd_q), x.c);
                    check("err_q", int'(err_q), x.e);
                end else begin
                    check("s_bcd_q_hold", int'(s_bcd_q), x.s);
                    check("cout_bcd_q_hold", int'(cout_bcd_q), x.c);
                    check("err_q_hold", int'(err_q), x.e);
                end
            end
        end
    end

    initial begin
        int ra, rb;
        int budget;
        // Reset, twice, with a valid input present that must be discarded.
        step(7, 6, 0, 1, 1);
        step(12, 1, 0, 1, 1);
        // Directed boundary cases.
        step(4, 3, 0, 1, 0);
        step(4, 5, 0, 1, 0);
        step(5, 5, 0, 1, 0);
        step(7, 6, 0, 1, 0);
        step(2, 3, 1, 0, 0);   // hold after 7+6
        step(9, 9, 0, 1, 0);
        step(9, 9, 1, 1, 0);
        step(9, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // Illegal digit sets the sticky flag, which survives legal traffic.
        step(12, 1, 0, 1, 0);
        step(15, 15, 1, 1, 0);
        step(3, 4, 0, 1, 0);
        step(1, 2, 0, 0, 0);
        // Illegal digit without in_valid must not set the flag after reset.
        step(0, 0, 0, 0, 1);
        step(14, 2, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        // Exhaustive legal sweep with random gaps in in_valid.
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                for (int k = 0; k < 2; k++)
                    step(i, j, k, int'($urandom_range(0, 3) != 0), 0);
        // Random traffic including illegal digits and occasional resets.
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            step(ra, rb, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 30) == 0));
        end
        step(0, 0, 0, 0, 0);
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
